// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch from a combinational memory into a
// 2-entry {instr, pc} buffer, with redirect flush and halt at LAST_PC.
module imem_fetch_ctrl #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = AW'(8'h00),
    parameter logic [AW-1:0] LAST_PC  = AW'(8'hFC)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] imem_a,
    input  logic [31:0]   imem_rd,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [31:0]   if_instr,
    output logic [AW-1:0] if_pc,
    output logic          halted
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31+AW:0]   e0_q, e1_q, e0_d, e1_d;
    logic             pop, fetch;
    logic [AW-1:0]    tgt;

    assign pop   = (cnt_q != 2'd0) && if_ready;
    assign fetch = (state_q == RUN) && en && !redirect_valid && ((cnt_q != 2'd2) || pop);
    assign tgt   = redirect_pc & ~AW'(3);

    // Entry 0 is always the head; a push lands in the first slot free after any pop.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (redirect_valid) begin
            cnt_d   = 2'd0;
            pc_d    = tgt;
            state_d = (tgt > LAST_PC) ? HALT : (en ? RUN : IDLE);
        end else begin
            if (pop)
                e0_d = e1_q;
            if (fetch) begin
                if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))
                    e0_d = {imem_rd, pc_q};
                else
                    e1_d = {imem_rd, pc_q};
                pc_d = (pc_q == LAST_PC) ? pc_q : pc_q + AW'(4);
            end
            cnt_d   = cnt_q + 2'(fetch) - 2'(pop);
            state_d = (state_q == IDLE) ? (en ? RUN : IDLE) :
                      (state_q == RUN)  ? ((fetch && pc_q == LAST_PC) ? HALT : (en ? RUN : IDLE)) :
                      HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign imem_a   = pc_q & ~AW'(3);
    assign if_valid = (cnt_q != 2'd0);
    assign if_instr = e0_q[31+AW:AW];
    assign if_pc    = e0_q[AW-1:0];
    assign halted   = (state_q == HALT);
endmodule
